// File: rtl/stall_producer.sv
// Two-lane stimulus generator: issues NUM_ITEMS seeded data words per lane per run,
// honours per-lane backpressure and emits periodic single-cycle flush pulses.
module stall_producer #(
   parameter int unsigned NUM_ITEMS    = 64,
   parameter int unsigned FLUSH_PERIOD = 16,
   parameter logic [31:0] SEED_1       = 32'h0000_1000,
   parameter logic [31:0] SEED_2       = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall_1,
   input  logic        stall_2,
   output logic [31:0] pipeline1_inputs,
   output logic [31:0] pipeline2_inputs,
   output logic [1:0]  in_valid,
   output logic        flush_1,
   output logic        flush_2,
   output logic        done
);

   typedef enum logic [1:0] {TOP_IDLE, TOP_RUN, TOP_DONE} top_state_e;
   typedef enum logic [1:0] {LANE_ACTIVE, LANE_FLUSH, LANE_FINISHED} lane_state_e;

   localparam logic [15:0]      NUM_ITEMS_C    = 16'(NUM_ITEMS);
   localparam logic [15:0]      FLUSH_PERIOD_C = 16'(FLUSH_PERIOD);
   localparam logic [1:0][31:0] SEED           = {SEED_2, SEED_1};

   top_state_e  top_q, top_d;
   lane_state_e lane_q [2];
   lane_state_e lane_d [2];
   logic [15:0] cnt_q  [2];
   logic [15:0] cnt_d  [2];
   logic [15:0] fcnt_q [2];
   logic [15:0] fcnt_d [2];
   logic [31:0] data_q [2];
   logic [31:0] data_d [2];
   logic [1:0]  valid_q, valid_d;
   logic [1:0]  flush_q, flush_d;
   logic        done_q, done_d;
   logic [1:0]  stall;

   assign stall = {stall_2, stall_1};

   // fcnt counts accepts since the last flush, so no divider is needed for the period check.
   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      top_d   = top_q;
      done_d  = done_q;
      valid_d = valid_q;
      flush_d = '0;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      data_d  = data_q;
      case (top_q)
         TOP_IDLE: begin
            if (start) begin
               top_d = TOP_RUN;
               for (int i = 0; i < 2; i++) begin
                  lane_d[i[0]]  = LANE_ACTIVE;
                  cnt_d[i[0]]   = '0;
                  fcnt_d[i[0]]  = '0;
                  data_d[i[0]]  = SEED[i[0]];
                  valid_d[i[0]] = 1'b1;
               end
            end
         end
         TOP_RUN: begin
            if (lane_q[0] == LANE_FINISHED && lane_q[1] == LANE_FINISHED) begin
               top_d  = TOP_DONE;
               done_d = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
               case (lane_q[i[0]])
                  LANE_ACTIVE: begin
                     if (!stall[i[0]]) begin
                        cnt_d[i[0]] = cnt_q[i[0]] + 16'd1;
                        if (cnt_d[i[0]] == NUM_ITEMS_C) begin
                           lane_d[i[0]]  = LANE_FINISHED;
                           valid_d[i[0]] = 1'b0;
                        end else if (FLUSH_PERIOD_C != 16'd0 &&
                                     fcnt_q[i[0]] + 16'd1 == FLUSH_PERIOD_C) begin
                           lane_d[i[0]]  = LANE_FLUSH;
                           fcnt_d[i[0]]  = '0;
                           flush_d[i[0]] = 1'b1;
                           valid_d[i[0]] = 1'b0;
                        end else begin
                           fcnt_d[i[0]] = fcnt_q[i[0]] + 16'd1;
                           data_d[i[0]] = SEED[i[0]] + {16'd0, cnt_d[i[0]]};
                        end
                     end
                  end
                  LANE_FLUSH: begin
                     lane_d[i[0]]  = LANE_ACTIVE;
                     valid_d[i[0]] = 1'b1;
                     data_d[i[0]]  = SEED[i[0]] + {16'd0, cnt_q[i[0]]};
                  end
                  default: ;
               endcase
            end
         end
         TOP_DONE: begin
            if (!start) begin
               top_d  = TOP_IDLE;
               done_d = 1'b0;
            end
         end
         default: top_d = TOP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         top_q   <= TOP_IDLE;
         done_q  <= 1'b0;
         valid_q <= '0;
         flush_q <= '0;
         for (int i = 0; i < 2; i++) begin
            lane_q[i[0]] <= LANE_FINISHED;
            cnt_q[i[0]]  <= '0;
            fcnt_q[i[0]] <= '0;
            data_q[i[0]] <= '0;
         end
      end else begin
         top_q   <= top_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         data_q  <= data_d;
      end
   end

   assign pipeline1_inputs = data_q[0];
   assign pipeline2_inputs = data_q[1];
   assign in_valid         = valid_q;
   assign flush_1          = flush_q[0];
   assign flush_2          = flush_q[1];
   assign done             = done_q;

endmodule

// File: tb/tb_stall_producer.sv
// Scoreboard bench for stall_producer: default instance plus two parameter variants
// (NUM_ITEMS=FLUSH_PERIOD=16, and a wrapping SEED_1 with NUM_ITEMS=4).
module tb_stall_producer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, stall_1, stall_2;
   logic [31:0] p1, p2;
   logic [1:0]  in_valid;
   logic        flush_1, flush_2, done;

   logic        start_b, start_c;
   logic        no_stall = 1'b0;
   logic [31:0] p1_b, p2_b, p1_c, p2_c;
   logic [1:0]  in_valid_b, in_valid_c;
   logic        flush_1_b, flush_2_b, flush_1_c, flush_2_c, done_b, done_c;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp1_q[$];
   logic [31:0] exp2_q[$];
   logic [31:0] expb_q[$];
   logic [31:0] expc_q[$];

   stall_producer dut (
      .clk(clk), .reset(reset), .start(start), .stall_1(stall_1), .stall_2(stall_2),
      .pipeline1_inputs(p1), .pipeline2_inputs(p2), .in_valid(in_valid),
      .flush_1(flush_1), .flush_2(flush_2), .done(done));

   stall_producer #(.NUM_ITEMS(16), .FLUSH_PERIOD(16)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .stall_1(no_stall), .stall_2(no_stall),
      .pipeline1_inputs(p1_b), .pipeline2_inputs(p2_b), .in_valid(in_valid_b),
      .flush_1(flush_1_b), .flush_2(flush_2_b), .done(done_b));

   stall_producer #(.NUM_ITEMS(4), .SEED_1(32'hFFFF_FFFE)) dut_c (
      .clk(clk), .reset(reset), .start(start_c), .stall_1(no_stall), .stall_2(no_stall),
      .pipeline1_inputs(p1_c), .pipeline2_inputs(p2_c), .in_valid(in_valid_c),
      .flush_1(flush_1_c), .flush_2(flush_2_c), .done(done_c));

   // An item is accepted at the next rising edge when valid is high and stall is low.
   always @(negedge clk) begin : scoreboard
      logic [31:0] e;
      if (reset === 1'b0) begin
         if (in_valid[0] === 1'b1 && stall_1 === 1'b0) begin
            checks++;
            if (exp1_q.size() == 0) begin
               errors++; $display("FAIL lane1_extra: got %h, required no item", p1);
            end else begin
               e = exp1_q.pop_front();
               if (p1 !== e) begin errors++; $display("FAIL lane1_data: got %h, required %h", p1, e); end
            end
         end
         if (in_valid[1] === 1'b1 && stall_2 === 1'b0) begin
            checks++;
            if (exp2_q.size() == 0) begin
               errors++; $display("FAIL lane2_extra: got %h, required no item", p2);
            end else begin
               e = exp2_q.pop_front();
               if (p2 !== e) begin errors++; $display("FAIL lane2_data: got %h, required %h", p2, e); end
            end
         end
         if (in_valid_b[0] === 1'b1) begin
            checks++;
            if (expb_q.size() == 0) begin
               errors++; $display("FAIL b_lane1_extra: got %h, required no item", p1_b);
            end else begin
               e = expb_q.pop_front();
               if (p1_b !== e) begin errors++; $display("FAIL b_lane1_data: got %h, required %h", p1_b, e); end
            end
         end
         if (in_valid_c[0] === 1'b1) begin
            checks++;
            if (expc_q.size() == 0) begin
               errors++; $display("FAIL c_lane1_extra: got %h, required no item", p1_c);
            end else begin
               e = expc_q.pop_front();
               if (p1_c !== e) begin errors++; $display("FAIL c_lane1_data: got %h, required %h", p1_c, e); end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input int lane, input logic [31:0] seed, input int n);
      for (int k = 0; k < n; k++) begin
         case (lane)
            1: exp1_q.push_back(seed + 32'(k));
            2: exp2_q.push_back(seed + 32'(k));
            default: expb_q.push_back(seed + 32'(k));
         endcase
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (p1 !== 32'd0 || p2 !== 32'd0) begin
         errors++; $display("FAIL reset_data: got %h/%h, required 0/0", p1, p2);
      end
      checks++;
      if (in_valid !== 2'b00 || flush_1 !== 1'b0 || flush_2 !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: got v=%b f=%b%b d=%b, required all 0", in_valid, flush_2, flush_1, done);
      end
      checks++;
      if (in_valid_b !== 2'b00 || in_valid_c !== 2'b00 || done_b !== 1'b0 || done_c !== 1'b0) begin
         errors++; $display("FAIL reset_variants: got vb=%b vc=%b, required 00/00", in_valid_b, in_valid_c);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (in_valid !== 2'b00 || done !== 1'b0) begin
         errors++; $display("FAIL idle_hold: got v=%b d=%b, required 00/0", in_valid, done);
      end
   endtask

   task automatic test_full_run();
      int acc1, acc2, n, last_n;
      bit a1, a2, f1, f2;
      push_seq(1, 32'h1000, 64);
      push_seq(2, 32'h2000, 64);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (in_valid !== 2'b11 || p1 !== 32'h1000 || p2 !== 32'h2000) begin
         errors++; $display("FAIL start_latency: got v=%b d1=%h d2=%h, required 11/1000/2000", in_valid, p1, p2);
      end
      acc1 = 0; acc2 = 0; n = 0; last_n = -1;
      while (done !== 1'b1 && n < 300) begin
         a1 = (in_valid[0] === 1'b1) && !stall_1;
         a2 = (in_valid[1] === 1'b1) && !stall_2;
         if (a1) begin acc1++; last_n = n; end
         if (a2) acc2++;
         tick();
         n++;
         f1 = a1 && (acc1 % 16 == 0) && (acc1 < 64);
         f2 = a2 && (acc2 % 16 == 0) && (acc2 < 64);
         checks++;
         if (flush_1 !== f1 || flush_2 !== f2) begin
            errors++; $display("FAIL full_flush: got %b%b at cycle %0d, required %b%b", flush_2, flush_1, n, f2, f1);
         end
      end
      checks++;
      if (done !== 1'b1 || n !== last_n + 2) begin
         errors++; $display("FAIL full_done: got done=%b at cycle %0d, required 1 at cycle %0d", done, n, last_n + 2);
      end
      checks++;
      if (acc1 != 64 || acc2 != 64 || exp1_q.size() != 0 || exp2_q.size() != 0) begin
         errors++; $display("FAIL full_count: got %0d/%0d accepts, required 64/64", acc1, acc2);
      end
      tick();
      checks++;
      if (done !== 1'b0 || in_valid !== 2'b00) begin
         errors++; $display("FAIL full_idle: got d=%b v=%b, required 0/00", done, in_valid);
      end
   endtask

   task automatic test_stall_hold();
      int n;
      push_seq(1, 32'h1000, 64);
      push_seq(2, 32'h2000, 64);
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (p1 !== 32'h1003 && n < 20) begin tick(); n++; end
      checks++;
      if (p1 !== 32'h1003) begin errors++; $display("FAIL stall_reach: got %h, required 1003", p1); end
      stall_1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (p1 !== 32'h1003 || in_valid[0] !== 1'b1) begin
            errors++; $display("FAIL stall_hold: got %h v=%b, required 1003 v=1", p1, in_valid[0]);
         end
      end
      checks++;
      if (p2 !== 32'h2007 || in_valid[1] !== 1'b1) begin
         errors++; $display("FAIL stall_lane2: got %h v=%b, required 2007 v=1", p2, in_valid[1]);
      end
      stall_1 = 1'b0;
      tick();
      checks++;
      if (p1 !== 32'h1004) begin errors++; $display("FAIL stall_release: got %h, required 1004", p1); end
      n = 0;
      while (done !== 1'b1 && n < 300) begin tick(); n++; end
      checks++;
      if (done !== 1'b1 || exp1_q.size() != 0 || exp2_q.size() != 0) begin
         errors++; $display("FAIL stall_done: got done=%b left=%0d/%0d, required 1/0/0", done, exp1_q.size(), exp2_q.size());
      end
      tick();
   endtask

   task automatic test_flush_stall();
      int n;
      push_seq(1, 32'h1000, 64);
      push_seq(2, 32'h2000, 64);
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (flush_2 !== 1'b1 && n < 40) begin tick(); n++; end
      checks++;
      if (flush_2 !== 1'b1 || in_valid[1] !== 1'b0 || p2 !== 32'h200F) begin
         errors++; $display("FAIL fstall_enter: got f=%b v=%b %h, required 1/0/200f", flush_2, in_valid[1], p2);
      end
      stall_2 = 1'b1;
      tick();
      checks++;
      if (flush_2 !== 1'b0 || in_valid[1] !== 1'b1 || p2 !== 32'h2010) begin
         errors++; $display("FAIL fstall_single: got f=%b v=%b %h, required 0/1/2010", flush_2, in_valid[1], p2);
      end
      tick();
      checks++;
      if (flush_2 !== 1'b0 || in_valid[1] !== 1'b1 || p2 !== 32'h2010) begin
         errors++; $display("FAIL fstall_hold: got f=%b v=%b %h, required 0/1/2010", flush_2, in_valid[1], p2);
      end
      checks++;
      if (p1 !== 32'h1011) begin errors++; $display("FAIL fstall_lane1: got %h, required 1011", p1); end
      stall_2 = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 300) begin tick(); n++; end
      checks++;
      if (done !== 1'b1 || exp1_q.size() != 0 || exp2_q.size() != 0) begin
         errors++; $display("FAIL fstall_done: got done=%b left=%0d/%0d, required 1/0/0", done, exp1_q.size(), exp2_q.size());
      end
      tick();
   endtask

   task automatic test_mid_reset();
      int n;
      push_seq(1, 32'h1000, 64);
      push_seq(2, 32'h2000, 64);
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (p1 !== 32'h1007 && n < 20) begin tick(); n++; end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (p1 !== 32'd0 || p2 !== 32'd0 || in_valid !== 2'b00 || flush_1 !== 1'b0 || flush_2 !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mreset_outputs: got %h %h v=%b f=%b%b d=%b, required all 0", p1, p2, in_valid, flush_2, flush_1, done);
      end
      exp1_q.delete();
      exp2_q.delete();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (in_valid !== 2'b00 || flush_1 !== 1'b0 || flush_2 !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mreset_quiet: got v=%b f=%b%b d=%b, required all 0", in_valid, flush_2, flush_1, done);
         end
      end
      push_seq(1, 32'h1000, 64);
      push_seq(2, 32'h2000, 64);
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (in_valid !== 2'b11 || p1 !== 32'h1000) begin
         errors++; $display("FAIL mreset_restart: got v=%b %h, required 11/1000", in_valid, p1);
      end
      n = 0;
      while (done !== 1'b1 && n < 300) begin tick(); n++; end
      checks++;
      if (done !== 1'b1 || exp1_q.size() != 0 || exp2_q.size() != 0) begin
         errors++; $display("FAIL mreset_done: got done=%b left=%0d/%0d, required 1/0/0", done, exp1_q.size(), exp2_q.size());
      end
      tick();
   endtask

   task automatic test_num16();
      int n, acc, last_n;
      push_seq(3, 32'h1000, 16);
      start_b = 1'b1; tick(); start_b = 1'b0;
      n = 0; acc = 0; last_n = -1;
      while (done_b !== 1'b1 && n < 100) begin
         if (in_valid_b[0] === 1'b1) begin acc++; last_n = n; end
         tick();
         n++;
         checks++;
         if (flush_1_b !== 1'b0 || flush_2_b !== 1'b0) begin
            errors++; $display("FAIL n16_flush: got %b%b at cycle %0d, required 00", flush_2_b, flush_1_b, n);
         end
      end
      checks++;
      if (done_b !== 1'b1 || acc != 16 || n != last_n + 2 || expb_q.size() != 0) begin
         errors++; $display("FAIL n16_done: got done=%b acc=%0d cyc=%0d, required 1/16/%0d", done_b, acc, n, last_n + 2);
      end
      tick();
   endtask

   task automatic test_wrap();
      int n;
      expc_q.push_back(32'hFFFF_FFFE);
      expc_q.push_back(32'hFFFF_FFFF);
      expc_q.push_back(32'h0000_0000);
      expc_q.push_back(32'h0000_0001);
      start_c = 1'b1; tick(); start_c = 1'b0;
      n = 0;
      while (done_c !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (done_c !== 1'b1 || expc_q.size() != 0) begin
         errors++; $display("FAIL wrap_done: got done=%b left=%0d, required 1/0", done_c, expc_q.size());
      end
      checks++;
      if (p1_c !== 32'h0000_0001 || in_valid_c !== 2'b00) begin
         errors++; $display("FAIL wrap_hold: got %h v=%b, required 00000001/00", p1_c, in_valid_c);
      end
      tick();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stall_1 = 1'b0; stall_2 = 1'b0;
      start_b = 1'b0; start_c = 1'b0;
      test_reset();
      test_full_run();
      test_stall_hold();
      test_flush_stall();
      test_mid_reset();
      test_num16();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
